// File: rtl/im_fetch_arbiter_if.sv
// im_fetch_arbiter_if: requester/memory-side bundle of the instruction memory fetch arbiter
interface im_fetch_arbiter_if;
    logic        req0;
    logic [31:0] addr0;
    logic        req1;
    logic [31:0] addr1;
    logic [31:0] im_d;
    logic [31:0] im_a;
    logic        gnt0;
    logic        gnt1;
    logic        rvalid0;
    logic        rvalid1;
    logic [31:0] rdata;
    logic        busy;

    modport master (
        output req0, addr0, req1, addr1, im_d,
        input  im_a, gnt0, gnt1, rvalid0, rvalid1, rdata, busy
    );

    modport slave (
        input  req0, addr0, req1, addr1, im_d,
        output im_a, gnt0, gnt1, rvalid0, rvalid1, rdata, busy
    );
endinterface

// File: rtl/im_fetch_arbiter.sv
// im_fetch_arbiter: round-robin sharing of one fixed-delay instruction memory port between
// CPU fetch (port 0) and loader/debug (port 1), one access in flight
module im_fetch_arbiter #(
    parameter int WAIT_CYCLES = 10,
    parameter int CW          = 4
) (
    input logic               clk,
    input logic               reset,
    im_fetch_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_owner;
    logic          r_last;
    logic          w_any;
    logic          w_pick;

    // On contention the port that was not served last wins; otherwise whoever asks
    assign w_any  = bus.req0 | bus.req1;
    assign w_pick = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            bus.im_a    <= '0;
            bus.rdata   <= '0;
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        bus.im_a <= w_pick ? bus.addr1 : bus.addr0;
                        bus.gnt0 <= ~w_pick;
                        bus.gnt1 <= w_pick;
                        bus.busy <= 1'b1;
                        r_owner  <= w_pick;
                        r_cnt    <= CNT_INIT;
                        r_state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) r_state <= DONE;
                    else r_cnt <= r_cnt - 1'b1;
                end
                DONE: begin
                    bus.rdata   <= bus.im_d;
                    bus.rvalid0 <= ~r_owner;
                    bus.rvalid1 <= r_owner;
                    bus.busy    <= 1'b0;
                    r_last      <= r_owner;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_im_fetch_arbiter.sv
// tb_im_fetch_arbiter: directed checks of the fetch arbiter with a behavioural instruction memory
module tb_im_fetch_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] mem [1024];

    im_fetch_arbiter_if if_a ();
    im_fetch_arbiter_if if_b ();

    im_fetch_arbiter #(.WAIT_CYCLES(10), .CW(4)) u_dut_a (.clk(clk), .reset(rst), .bus(if_a));
    im_fetch_arbiter #(.WAIT_CYCLES(1),  .CW(4)) u_dut_b (.clk(clk), .reset(rst), .bus(if_b));

    assign if_a.im_d = mem[if_a.im_a[11:2]];
    assign if_b.im_d = mem[if_b.im_a[11:2]];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int grant_port [6];
        int grant_cyc  [6];
        int n_grant;
        int overlap;
        int cnt_gnt;
        int cnt_rv;
        logic [31:0] cap;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[2] = 32'h2010_0005;
        {if_a.req0, if_a.req1, if_b.req0, if_b.req1} = '0;
        {if_a.addr0, if_a.addr1, if_b.addr0, if_b.addr1} = '0;
        #3;
        check("rst_im_a",   if_a.im_a, 32'h0);
        check("rst_rdata",  if_a.rdata, 32'h0);
        check("rst_flags",  {if_a.gnt0, if_a.gnt1, if_a.rvalid0, if_a.rvalid1, if_a.busy}, 0);
        step(2);
        rst = 1'b0;

        // single port-0 access, full wait latency
        if_a.req0 = 1'b1; if_a.addr0 = 32'h0000_0008;
        step();
        check("t2_gnt0", {if_a.gnt0, if_a.gnt1}, 2'b10);
        check("t2_im_a", if_a.im_a, 32'h8);
        check("t2_busy", if_a.busy, 1'b1);
        if_a.req0 = 1'b0;
        step(10);
        check("t2_early", {if_a.rvalid0, if_a.busy}, 2'b01);
        step();
        check("t2_rvalid", {if_a.rvalid0, if_a.rvalid1, if_a.busy}, 3'b100);
        check("t2_rdata", if_a.rdata, 32'h2010_0005);
        step();
        check("t2_pulse", if_a.rvalid0, 1'b0);
        check("t2_hold", if_a.rdata, 32'h2010_0005);

        // simultaneous requests after reset: port 0 first
        pulse_reset();
        if_a.req0 = 1'b1; if_a.req1 = 1'b1; if_a.addr0 = 32'h0; if_a.addr1 = 32'h4;
        step();
        check("t3_first", {if_a.gnt0, if_a.gnt1}, 2'b10);
        if_a.req0 = 1'b0;
        step(11);
        check("t3_rv0", {if_a.rvalid0, if_a.rvalid1}, 2'b10);
        check("t3_rd0", if_a.rdata, mem[0]);
        step();
        check("t3_second", {if_a.gnt0, if_a.gnt1}, 2'b01);
        check("t3_im_a", if_a.im_a, 32'h4);
        if_a.req1 = 1'b0;
        step(11);
        check("t3_rv1", {if_a.rvalid0, if_a.rvalid1}, 2'b01);
        check("t3_rd1", if_a.rdata, mem[1]);

        // sustained contention: strict alternation, one grant per 12 cycles
        if_a.req0 = 1'b1; if_a.req1 = 1'b1;
        n_grant = 0; overlap = 0;
        for (int c = 0; c < 100 && n_grant < 6; c++) begin
            step();
            if ((if_a.gnt0 & if_a.gnt1) | (if_a.rvalid0 & if_a.rvalid1)) overlap++;
            if (if_a.gnt0 | if_a.gnt1) begin
                grant_port[n_grant] = if_a.gnt1 ? 1 : 0;
                grant_cyc[n_grant]  = c;
                n_grant++;
            end
        end
        if_a.req0 = 1'b0; if_a.req1 = 1'b0;
        check("t4_count", n_grant, 6);
        check("t4_overlap", overlap, 0);
        for (int i = 0; i < n_grant; i++) check($sformatf("t4_port%0d", i), grant_port[i], i % 2);
        for (int i = 1; i < n_grant; i++) check($sformatf("t4_period%0d", i), grant_cyc[i] - grant_cyc[i-1], 12);
        step(13);

        // reset in the middle of a wait: access abandoned
        if_a.req0 = 1'b1; if_a.addr0 = 32'h40;
        step();
        check("t1_gnt", if_a.gnt0, 1'b1);
        if_a.req0 = 1'b0;
        step(4);
        check("t1_busy_pre", if_a.busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("t1_im_a", if_a.im_a, 32'h0);
        check("t1_rdata", if_a.rdata, 32'h0);
        check("t1_flags", {if_a.gnt0, if_a.gnt1, if_a.rvalid0, if_a.rvalid1, if_a.busy}, 0);
        step();
        rst = 1'b0;
        cnt_rv = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (if_a.rvalid0 | if_a.rvalid1 | if_a.busy) cnt_rv++;
        end
        check("t1_no_rvalid", cnt_rv, 0);

        // port 1 drops its request one cycle after grant
        if_a.req1 = 1'b1; if_a.addr1 = 32'h0000_0FFC;
        step();
        check("t5_gnt1", {if_a.gnt0, if_a.gnt1}, 2'b01);
        step();
        if_a.req1 = 1'b0;
        cnt_gnt = 0; cnt_rv = 0; cap = '0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (if_a.gnt0 | if_a.gnt1) cnt_gnt++;
            if (if_a.rvalid1) begin
                cnt_rv++;
                cap = if_a.rdata;
            end
        end
        check("t5_regrant", cnt_gnt, 0);
        check("t5_rv_cnt", cnt_rv, 1);
        check("t5_rdata", cap, mem[1023]);

        // short-latency instance, misaligned address passed through
        if_b.req0 = 1'b1; if_b.addr0 = 32'h0000_0013;
        step();
        check("t6_gnt0", if_b.gnt0, 1'b1);
        check("t6_im_a", if_b.im_a, 32'h13);
        if_b.req0 = 1'b0;
        step();
        check("t6_early", if_b.rvalid0, 1'b0);
        step();
        check("t6_rvalid", if_b.rvalid0, 1'b1);
        check("t6_rdata", if_b.rdata, mem[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
